hazard_flush_controller: RTL and testbench

HAZARD_FLUSH_CONTROLLER -- requirements
Module: hazard_flush_controller

---
 rtl/pipeline_ctrl_pkg.sv | 46 ++++
 rtl/sat_counter.sv | 39 +++
 rtl/hazard_flush_controller.sv | 156 +++++++++++++++
 tb/tb_hazard_flush_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings for the pipeline hazard/flush controller
//
// Purpose : FSM state encoding, ALU forward-select codes, flush bit indices
//           and small register-compare helpers shared by the controller.
// Ports   : none (package).
package pipeline_ctrl_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // ALU operand forward selects
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  // Bit positions inside the 3-bit flush vector
  localparam int FLUSH_IFID  = 2;
  localparam int FLUSH_IDEX  = 1;
  localparam int FLUSH_EXMEM = 0;

  // Register 0 is hard-wired to zero, so it can never carry a dependency.
  // rt only counts when the IF/ID instruction actually reads it.
  function automatic logic reg_hit(input logic [4:0] rd,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic       use_rt);
    return (rd != 5'd0) && ((rd == rs) || (use_rt && (rd == rt)));
  endfunction

  // MEM-stage producer is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                            input logic [4:0] mem_rd,
                                            input logic       mem_we,
                                            input logic [4:0] wb_rd,
                                            input logic       wb_we);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return FWD_MEM;
    end
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return FWD_WB;
    end
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with async active-high reset
//
// Purpose : counts cycles where inc is high, holding at all-ones.
// Ports   : clk   - clock
//           reset - asynchronous active-high reset, clears count
//           inc   - increment request for this cycle
//           count - current count value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_flush_controller.sv
// rtl/hazard_flush_controller.sv - pipeline stall/flush sequencer with optional ALU forwarding
//
// Purpose : detects RAW hazards between the IF/ID instruction and older
//           in-flight producers, holds the front end for the required number
//           of cycles while bubbling ID/EX, squashes the younger stages on a
//           MEM-resolved redirect, and selects ALU operand forwarding.
// Config  : HAZARD_FORWARD_EN - when defined, forwarding is built in and only
//           load-use stalls remain (depth <= 1); when undefined, forward
//           selects are constant 00 and the full 3/2/1 stall depths apply.
// Ports   : clk, reset            - clock, async active-high reset
//           id_rs/id_rt/id_uses_rt - IF/ID source registers
//           ex_rs/ex_rt/ex_rd      - ID/EX sources and EX destination
//           ex_reg_write/ex_mem_read, mem_rd/mem_reg_write,
//           wb_rd/wb_reg_write     - producer info for EX, MEM, WB
//           mem_redirect           - PC redirect resolved in MEM
//           front_enable           - PC and IF/ID enable (0 = hold)
//           flush                  - bubble insert {IF/ID, ID/EX, EX/MEM}
//           forward_a/forward_b    - ALU operand source selects
//           stall_count/flush_count - saturating event counters
module hazard_flush_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic [4:0]         ex_rs,
  input  logic [4:0]         ex_rt,
  input  logic [4:0]         ex_rd,
  input  logic               ex_reg_write,
  input  logic               ex_mem_read,
  input  logic [4:0]         mem_rd,
  input  logic               mem_reg_write,
  input  logic [4:0]         wb_rd,
  input  logic               wb_reg_write,
  input  logic               mem_redirect,
  output logic               front_enable,
  output logic [2:0]         flush,
  output logic [1:0]         forward_a,
  output logic [1:0]         forward_b,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic [1:0] rem_q;
  logic [1:0] rem_d;

  logic       ex_hit;
  logic [1:0] depth;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
  logic [2:0] flush_d;

  assign ex_hit = ex_reg_write & reg_hit(ex_rd, id_rs, id_rt, id_uses_rt);

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time: one bubble covers it.
  assign depth = (ex_hit & ex_mem_read) ? 2'd1 : 2'd0;

  assign fwd_a = fwd_select(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = fwd_select(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
`else
  logic mem_hit;
  logic wb_hit;
  logic unused_fwd_inputs;

  assign mem_hit = mem_reg_write & reg_hit(mem_rd, id_rs, id_rt, id_uses_rt);
  assign wb_hit  = wb_reg_write  & reg_hit(wb_rd,  id_rs, id_rt, id_uses_rt);

  // Wait until the producer has left WB; the nearest producer sets the depth.
  assign depth = ex_hit  ? 2'd3 :
                 mem_hit ? 2'd2 :
                 wb_hit  ? 2'd1 : 2'd0;

  assign fwd_a = FWD_NONE;
  assign fwd_b = FWD_NONE;

  // ID/EX sources and the load flag only matter to the forwarding path.
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, ex_mem_read};
`endif

  // Mealy next-state/output logic. A redirect squashes everything younger
  // than MEM, including any stalled instruction, so it overrides the stall.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    flush_d = 3'b000;
    if (mem_redirect) begin
      state_d = ST_RUN;
      rem_d   = 2'd0;
      flush_d[FLUSH_IFID]  = 1'b1;
      flush_d[FLUSH_IDEX]  = 1'b1;
      flush_d[FLUSH_EXMEM] = 1'b1;
    end else if (state_q == ST_STALL) begin
      stall               = 1'b1;
      flush_d[FLUSH_IDEX] = 1'b1;
      if (rem_q <= 2'd1) begin
        state_d = ST_RUN;
        rem_d   = 2'd0;
      end else begin
        rem_d   = rem_q - 2'd1;
      end
    end else if (depth != 2'd0) begin
      stall               = 1'b1;
      flush_d[FLUSH_IDEX] = 1'b1;
      // The current cycle is the first stall cycle; STALL covers the rest.
      if (depth > 2'd1) begin
        state_d = ST_STALL;
        rem_d   = depth - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs are partly combinational from the inputs, so reset must gate
  // them directly to hold the pipeline quiet while reset is high.
  assign front_enable = reset | ~stall;
  assign flush        = reset ? 3'b000 : flush_d;
  assign forward_a    = reset ? FWD_NONE : fwd_a;
  assign forward_b    = reset ? FWD_NONE : fwd_b;

  sat_counter #(
    .WIDTH (COUNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (~front_enable),
    .count (stall_count)
  );

  sat_counter #(
    .WIDTH (COUNT_W)
  ) u_flush_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_redirect),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_flush_controller.sv
// tb/tb_hazard_flush_controller.sv - directed self-checking bench for hazard_flush_controller
module tb_hazard_flush_controller;

  localparam int CW = 4;

`ifdef HAZARD_FORWARD_EN
  localparam int D_LOAD = 1;
  localparam int D_EX   = 0;
  localparam int D_MEM  = 0;
  localparam int D_WB   = 0;
  localparam logic [1:0] F_MEM = 2'b10;
  localparam logic [1:0] F_WB  = 2'b01;
`else
  localparam int D_LOAD = 3;
  localparam int D_EX   = 3;
  localparam int D_MEM  = 2;
  localparam int D_WB   = 1;
  localparam logic [1:0] F_MEM = 2'b00;
  localparam logic [1:0] F_WB  = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rt, ex_reg_write, ex_mem_read;
  logic          mem_reg_write, wb_reg_write, mem_redirect;
  logic          front_enable;
  logic [2:0]    flush;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] stall_count, flush_count;

  int n_checks  = 0;
  int n_errors  = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_flush_controller #(.COUNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .mem_redirect  (mem_redirect),
    .front_enable  (front_enable),
    .flush         (flush),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0;
    wb_rd = 5'd0; wb_reg_write = 1'b0;
    mem_redirect = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    clear_inputs();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
  endtask

  task automatic add_stall(input int n);
    exp_stall = (exp_stall + n > 15) ? 15 : exp_stall + n;
  endtask

  // Hazard inputs are already applied just after a rising edge; they are
  // withdrawn after the first edge, as the producer would move on.
  task automatic expect_stall(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_fe_stall"}, 32'(front_enable), 32'd0);
      check({tag, "_flush_stall"}, 32'(flush), 32'b010);
      step();
      clear_inputs();
    end
    @(negedge clk);
    check({tag, "_fe_run"}, 32'(front_enable), 32'd1);
    check({tag, "_flush_run"}, 32'(flush), 32'd0);
    add_stall(n);
    check({tag, "_stall_count"}, 32'(stall_count), 32'(exp_stall));
    step();
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  zeros;
    logic done;

    // Reset with a hazard and forwarding candidates present: outputs forced.
    set_load_use();
    mem_rd = 5'd5; mem_reg_write = 1'b1; ex_rs = 5'd5;
    reset = 1'b1;
    #3;
    check("rst_fe", 32'(front_enable), 32'd1);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_fwd_a", 32'(forward_a), 32'd0);
    check("rst_fwd_b", 32'(forward_b), 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);
    check("rst_flush_count", 32'(flush_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    step();
    @(negedge clk);
    check("idle_fe", 32'(front_enable), 32'd1);
    check("idle_flush", 32'(flush), 32'd0);
    step();

    // Load-use: ex_rd=8 loaded, IF/ID reads rs=8.
    set_load_use();
    expect_stall("load_use", D_LOAD);

    // EX producer, rt read.
    ex_reg_write = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    expect_stall("ex_rt", D_EX);

    // MEM producer, rt read.
    mem_reg_write = 1'b1; mem_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    expect_stall("mem_rt", D_MEM);

    // WB producer, rs read.
    wb_reg_write = 1'b1; wb_rd = 5'd4; id_rs = 5'd4;
    expect_stall("wb_rs", D_WB);

    // rt match but instruction does not read rt.
    ex_reg_write = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
    expect_stall("rt_unused", 0);

    // Register 0 never hazards.
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    expect_stall("reg_zero", 0);

    // EX and WB both match: nearest (EX) decides.
    ex_reg_write = 1'b1; ex_rd = 5'd7; wb_reg_write = 1'b1; wb_rd = 5'd7; id_rs = 5'd7;
    expect_stall("nearest", D_EX);

    // Redirect arriving in the second stall cycle.
    set_load_use();
    @(negedge clk);
    check("redir_first_fe", 32'(front_enable), 32'd0);
    step();
    clear_inputs();
    mem_redirect = 1'b1;
    @(negedge clk);
    check("redir_fe", 32'(front_enable), 32'd1);
    check("redir_flush", 32'(flush), 32'b111);
    step();
    clear_inputs();
    add_stall(1);
    exp_flush = 1;
    @(negedge clk);
    check("redir_after_fe", 32'(front_enable), 32'd1);
    check("redir_after_flush", 32'(flush), 32'd0);
    check("redir_flush_count", 32'(flush_count), 32'(exp_flush));
    check("redir_stall_count", 32'(stall_count), 32'(exp_stall));
    step();

    // Redirect in RUN overrides a fresh hazard.
    set_load_use();
    mem_redirect = 1'b1;
    @(negedge clk);
    check("redir_run_fe", 32'(front_enable), 32'd1);
    check("redir_run_flush", 32'(flush), 32'b111);
    step();
    clear_inputs();
    exp_flush = 2;
    @(negedge clk);
    check("redir_run_fe_after", 32'(front_enable), 32'd1);
    check("redir_run_flush_count", 32'(flush_count), 32'(exp_flush));
    check("redir_run_stall_count", 32'(stall_count), 32'(exp_stall));
    step();

    // Forward priority (IF/ID regs stay 0 so no stall).
    mem_rd = 5'd5; wb_rd = 5'd5; ex_rs = 5'd5; ex_rt = 5'd5;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    #1;
    check("fwd_a_mem", 32'(forward_a), 32'(F_MEM));
    check("fwd_b_mem", 32'(forward_b), 32'(F_MEM));
    check("fwd_fe", 32'(front_enable), 32'd1);
    mem_rd = 5'd0;
    #1;
    check("fwd_a_wb", 32'(forward_a), 32'(F_WB));
    check("fwd_b_wb", 32'(forward_b), 32'(F_WB));
    ex_rs = 5'd0;
    #1;
    check("fwd_a_zero", 32'(forward_a), 32'd0);
    check("fwd_b_still_wb", 32'(forward_b), 32'(F_WB));
    mem_rd = 5'd5; mem_reg_write = 1'b0;
    #1;
    check("fwd_b_mem_nowrite", 32'(forward_b), 32'(F_WB));
    clear_inputs();
    step();

    // Saturation: hold a load-use hazard for 20 cycles.
    set_load_use();
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!front_enable) zeros++;
      step();
    end
    check("sat_window", 32'(zeros), 32'd20);
    clear_inputs();
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!done) begin
        @(negedge clk);
        if (front_enable) done = 1'b1;
        else step();
      end
    end
    check("sat_drain", 32'(done), 32'd1);
    check("sat_stall_count", 32'(stall_count), 32'd15);
    check("sat_flush_count", 32'(flush_count), 32'(exp_flush));
    step();

    // Reset asserted mid-stall.
    set_load_use();
    step();
    mem_rd = 5'd5; mem_reg_write = 1'b1; ex_rs = 5'd5;
    #2;
    check("pre_reset_stall", 32'(front_enable), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_fe", 32'(front_enable), 32'd1);
    check("mid_rst_flush", 32'(flush), 32'd0);
    check("mid_rst_fwd_a", 32'(forward_a), 32'd0);
    check("mid_rst_stall_count", 32'(stall_count), 32'd0);
    check("mid_rst_flush_count", 32'(flush_count), 32'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("post_rst_fe", 32'(front_enable), 32'd1);
      check("post_rst_flush", 32'(flush), 32'd0);
    end
    check("post_rst_stall_count", 32'(stall_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
